// File: rtl/mem_access_ctrl_if.sv
// mem_access_ctrl_if: CPU/ext request handshakes, memory data register strobes and DRAM port
interface mem_access_ctrl_if #(parameter int ADDR_W = 16);
  logic cpu_req, cpu_we, cpu_ack;
  logic [ADDR_W-1:0] cpu_addr;
  logic ext_req, ext_we, ext_ack;
  logic [ADDR_W-1:0] ext_addr;
  logic [7:0] ext_wdata, ext_rdata;
  logic [7:0] mdr_wdata;
  logic read_memory, write_memory;
  logic dram_en, dram_we;
  logic [ADDR_W-1:0] dram_addr;
  logic [7:0] dram_wdata, dram_rdata;
  logic busy;
  modport slave (
    input cpu_req, cpu_we, cpu_addr, ext_req, ext_we, ext_addr, ext_wdata, mdr_wdata, dram_rdata,
    output cpu_ack, ext_ack, ext_rdata, read_memory, write_memory, dram_en, dram_we, dram_addr, dram_wdata, busy
  );
  modport master (
    output cpu_req, cpu_we, cpu_addr, ext_req, ext_we, ext_addr, ext_wdata, mdr_wdata, dram_rdata,
    input cpu_ack, ext_ack, ext_rdata, read_memory, write_memory, dram_en, dram_we, dram_addr, dram_wdata, busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: round-robin arbiter and transaction sequencer for one DRAM port shared by CPU and ext
module mem_access_ctrl #(
  parameter int ADDR_W   = 16,
  parameter int READ_LAT = 2
) (
  input logic clk,
  input logic rstn,
  mem_access_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, W_LATCH, W_ISSUE, R_ISSUE, R_WAIT, R_CAPT, ACK} state_t;
  localparam logic [3:0] LAT_M1 = 4'(READ_LAT - 1);
  state_t state_q, state_d;
  logic owner_q, owner_d;
  logic last_cpu_q, last_cpu_d;
  logic we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] ext_rdata_q, ext_rdata_d;
  logic grant_cpu;
  // owner/last_grant are 1 for CPU; ext wins a tie only right after a CPU grant
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_cpu_d  = last_cpu_q;
    we_d        = we_q;
    addr_d      = addr_q;
    cnt_d       = cnt_q;
    ext_rdata_d = ext_rdata_q;
    grant_cpu   = bus.cpu_req && !(bus.ext_req && last_cpu_q);
    case (state_q)
      IDLE: if (bus.cpu_req || bus.ext_req) begin
        owner_d    = grant_cpu;
        last_cpu_d = grant_cpu;
        we_d       = grant_cpu ? bus.cpu_we : bus.ext_we;
        addr_d     = grant_cpu ? bus.cpu_addr : bus.ext_addr;
        state_d    = !we_d ? R_ISSUE : grant_cpu ? W_LATCH : W_ISSUE;
      end
      W_LATCH: state_d = W_ISSUE;
      W_ISSUE: state_d = ACK;
      R_ISSUE: begin
        cnt_d   = LAT_M1;
        state_d = READ_LAT > 1 ? R_WAIT : R_CAPT;
      end
      R_WAIT: begin
        cnt_d   = cnt_q - 4'd1;
        state_d = cnt_q == 4'd1 ? R_CAPT : R_WAIT;
      end
      R_CAPT: begin
        ext_rdata_d = owner_q ? ext_rdata_q : bus.dram_rdata;
        state_d     = ACK;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      last_cpu_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      cnt_q       <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_cpu_q  <= last_cpu_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      cnt_q       <= cnt_d;
      ext_rdata_q <= ext_rdata_d;
    end
  // mdr_wdata is sampled live in W_ISSUE: the data register only loads it at the end of W_LATCH
  assign bus.busy         = state_q != IDLE;
  assign bus.write_memory = state_q == W_LATCH;
  assign bus.read_memory  = state_q == R_CAPT && owner_q;
  assign bus.dram_en      = state_q == W_ISSUE || state_q == R_ISSUE;
  assign bus.dram_we      = state_q == W_ISSUE;
  assign bus.dram_addr    = addr_q;
  assign bus.dram_wdata   = state_q != W_ISSUE ? 8'h00 : owner_q ? bus.mdr_wdata : bus.ext_wdata;
  assign bus.cpu_ack      = state_q == ACK && owner_q;
  assign bus.ext_ack      = state_q == ACK && !owner_q;
  assign bus.ext_rdata    = ext_rdata_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: two controllers (READ_LAT 2 and 1) checked every cycle against a transaction-level model,
// plus a latency table and hand-written corner sequences
module tb_mem_access_ctrl;
  localparam int AW = 16;
  logic clk = 1'b0, rstn = 1'b0;
  always #5 clk = ~clk;
  logic cpu_req = 0, cpu_we = 0, ext_req = 0, ext_we = 0;
  logic [AW-1:0] cpu_addr = '0, ext_addr = '0;
  logic [7:0] ext_wdata = '0, dram_rdata = '0, c_bus = '0;
  int checks = 0, errors = 0;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = g ? 1 : 2;
    mem_access_ctrl_if #(.ADDR_W(AW)) ifc ();
    logic [7:0] mdr_w = '0, mdr_r = '0;
    int m_t = 0, m_len = 3;
    logic m_own = 0, m_we = 0, m_last = 0;
    logic [AW-1:0] m_addr = '0;
    logic [7:0] m_erd = '0, e_wd;
    logic e_en;
    assign ifc.cpu_req    = cpu_req;
    assign ifc.cpu_we     = cpu_we;
    assign ifc.cpu_addr   = cpu_addr;
    assign ifc.ext_req    = ext_req;
    assign ifc.ext_we     = ext_we;
    assign ifc.ext_addr   = ext_addr;
    assign ifc.ext_wdata  = ext_wdata;
    assign ifc.mdr_wdata  = mdr_w;
    assign ifc.dram_rdata = dram_rdata;
    mem_access_ctrl #(.ADDR_W(AW), .READ_LAT(LAT)) dut (.clk(clk), .rstn(rstn), .bus(ifc.slave));
    // memory data register environment
    always @(posedge clk) begin
      if (ifc.write_memory) mdr_w <= c_bus;
      if (ifc.read_memory) mdr_r <= dram_rdata;
    end
    // reference: a transaction of length L runs t = 1..L after its grant cycle, ack at t == L
    always @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        m_t = 0; m_last = 0; m_own = 0; m_we = 0; m_addr = '0; m_erd = '0;
      end else if (m_t != 0) begin
        if (!m_own && !m_we && m_t == m_len - 1) m_erd = dram_rdata;
        m_t = m_t == m_len ? 0 : m_t + 1;
      end else if (cpu_req || ext_req) begin
        m_own  = cpu_req && !(ext_req && m_last);
        m_last = m_own;
        m_we   = m_own ? cpu_we : ext_we;
        m_addr = m_own ? cpu_addr : ext_addr;
        m_len  = m_own && m_we ? 3 : m_we ? 2 : LAT + 2;
        m_t    = 1;
      end
    end
    always @(negedge clk) begin
      e_en = m_t != 0 && (m_we ? m_t == m_len - 1 : m_t == 1);
      e_wd = e_en && m_we ? (m_own ? mdr_w : ext_wdata) : 8'h00;
      chk($sformatf("model_lat%0d t=%0d", LAT, m_t),
          {ifc.busy, ifc.write_memory, ifc.read_memory, ifc.dram_en, ifc.dram_we, ifc.dram_addr,
           ifc.dram_wdata, ifc.cpu_ack, ifc.ext_ack, ifc.ext_rdata},
          {m_t != 0, m_t == 1 && m_own && m_we, m_t != 0 && m_own && !m_we && m_t == m_len - 1,
           e_en, e_en && m_we, m_addr, e_wd, m_t != 0 && m_t == m_len && m_own,
           m_t != 0 && m_t == m_len && !m_own, m_erd});
    end
  end

  logic [38:0] o0;
  assign o0 = {u[0].ifc.busy, u[0].ifc.write_memory, u[0].ifc.read_memory, u[0].ifc.dram_en, u[0].ifc.dram_we,
               u[0].ifc.dram_addr, u[0].ifc.dram_wdata, u[0].ifc.cpu_ack, u[0].ifc.ext_ack, u[0].ifc.ext_rdata};
  logic [AW-1:0] sn_a = '0;
  logic [7:0] sn_d = '0;
  always @(posedge clk) if (u[0].ifc.dram_en && u[0].ifc.dram_we) begin
    sn_a <= u[0].ifc.dram_addr;
    sn_d <= u[0].ifc.dram_wdata;
  end

  typedef struct {logic cpu; logic we; logic [AW-1:0] addr; logic [7:0] data; int lat;} vec_t;
  vec_t tbl[6];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    cpu_req = 0;
    ext_req = 0;
    repeat (8) tick();
  endtask

  task automatic wait_ack(output int lat, output logic cpu);
    lat = -1;
    cpu = 0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(negedge clk);
      if (u[0].ifc.cpu_ack || u[0].ifc.ext_ack) begin
        lat = k;
        cpu = u[0].ifc.cpu_ack;
      end
    end
    @(posedge clk);
    #1;
    cpu_req = 0;
    ext_req = 0;
  endtask

  initial begin
    int lat, n;
    logic who_cpu, rm_seen;
    int cyc[4];
    logic [3:0] who;
    tbl[0] = '{1'b1, 1'b1, 16'h0000, 8'h11, 3};
    tbl[1] = '{1'b0, 1'b1, 16'hFFFF, 8'h22, 2};
    tbl[2] = '{1'b1, 1'b0, 16'h8000, 8'h00, 4};
    tbl[3] = '{1'b0, 1'b0, 16'h7FFF, 8'h00, 4};
    tbl[4] = '{1'b1, 1'b1, 16'hFFFF, 8'hFF, 3};
    tbl[5] = '{1'b0, 1'b1, 16'h0000, 8'h5A, 2};
    repeat (2) tick();
    @(negedge clk);
    chk("reset outputs", o0, '0);
    @(posedge clk);
    #1 rstn = 1;
    repeat (2) tick();

    // reset during R_WAIT abandons the read; CPU then wins contention
    cpu_we = 0; ext_we = 0; cpu_addr = 16'h0AAA; ext_addr = 16'h0BBB; cpu_req = 1;
    repeat (3) @(negedge clk);
    chk("busy before reset", u[0].ifc.busy, 1);
    #2 rstn = 0;
    #1 chk("outputs in reset", o0, '0);
    ext_req = 1;
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    wait_ack(lat, who_cpu);
    chk("first grant after reset is cpu", who_cpu, 1);
    chk("cpu read latency after reset", lat, 4);
    settle();

    // CPU write through the data register
    cpu_we = 1; cpu_addr = 16'h0123; c_bus = 8'hA5; cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("cpu wr write_memory T1", u[0].ifc.write_memory, 1);
    @(negedge clk);
    chk("cpu wr issue T2", {u[0].ifc.dram_en, u[0].ifc.dram_we, u[0].ifc.dram_addr, u[0].ifc.dram_wdata,
        u[0].ifc.cpu_ack}, {1'b1, 1'b1, 16'h0123, 8'hA5, 1'b0});
    @(negedge clk);
    chk("cpu wr acks T3", {u[0].ifc.cpu_ack, u[0].ifc.ext_ack}, 2'b10);
    @(posedge clk);
    #1 cpu_req = 0;
    settle();

    // CPU read, READ_LAT 2
    cpu_we = 0; cpu_addr = 16'h0456; dram_rdata = 8'h00; cpu_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("cpu rd issue T1", {u[0].ifc.dram_en, u[0].ifc.dram_we, u[0].ifc.dram_addr}, {1'b1, 1'b0, 16'h0456});
    @(negedge clk);
    @(posedge clk);
    #1 dram_rdata = 8'h3C;
    @(negedge clk);
    chk("cpu rd read_memory T3", u[0].ifc.read_memory, 1);
    @(posedge clk);
    #1 dram_rdata = 8'h00;
    @(negedge clk);
    chk("cpu rd ack T4", u[0].ifc.cpu_ack, 1);
    chk("mdr holds read data", u[0].mdr_r, 8'h3C);
    @(posedge clk);
    #1 cpu_req = 0;
    settle();

    // EXT read on the READ_LAT 1 controller
    ext_we = 0; ext_addr = 16'h1234; ext_req = 1; rm_seen = 0;
    @(negedge clk);
    @(negedge clk);
    rm_seen |= u[1].ifc.read_memory;
    @(posedge clk);
    #1 dram_rdata = 8'h7E;
    @(negedge clk);
    rm_seen |= u[1].ifc.read_memory;
    @(posedge clk);
    #1 dram_rdata = 8'h00;
    @(negedge clk);
    rm_seen |= u[1].ifc.read_memory;
    chk("ext rd lat1 ack+data T3", {u[1].ifc.ext_ack, u[1].ifc.ext_rdata}, {1'b1, 8'h7E});
    chk("ext rd no read_memory", rm_seen, 0);
    @(posedge clk);
    #1 ext_req = 0;
    settle();

    // EXT write at the top address
    ext_we = 1; ext_addr = 16'hFFFF; ext_wdata = 8'hFF; ext_req = 1;
    @(negedge clk);
    @(negedge clk);
    chk("ext wr issue T1", {u[0].ifc.dram_en, u[0].ifc.dram_we, u[0].ifc.dram_addr, u[0].ifc.dram_wdata,
        u[0].ifc.write_memory}, {1'b1, 1'b1, 16'hFFFF, 8'hFF, 1'b0});
    @(negedge clk);
    chk("ext wr ack T2", {u[0].ifc.ext_ack, u[0].ifc.write_memory}, 2'b10);
    @(posedge clk);
    #1 ext_req = 0;
    settle();

    // continuous contention, both writes
    cpu_we = 1; ext_we = 1; cpu_addr = 16'h0C0C; ext_addr = 16'h0E0E; c_bus = 8'h33; ext_wdata = 8'h44;
    cpu_req = 1; ext_req = 1; n = 0; who = '0; cyc = '{0, 0, 0, 0};
    for (int k = 0; k < 60 && n < 4; k++) begin
      @(negedge clk);
      if (u[0].ifc.cpu_ack || u[0].ifc.ext_ack) begin
        cyc[n] = k;
        who[3-n] = u[0].ifc.cpu_ack;
        n++;
      end
    end
    chk("contention ack count", n, 4);
    chk("contention order", who, 4'b1010);
    chk("gap cpu->ext", cyc[1] - cyc[0], 3);
    chk("gap ext->cpu", cyc[2] - cyc[1], 4);
    chk("gap cpu->ext 2", cyc[3] - cyc[2], 3);
    settle();

    for (int i = 0; i < 6; i++) begin
      cpu_req = tbl[i].cpu; ext_req = !tbl[i].cpu; cpu_we = tbl[i].we; ext_we = tbl[i].we;
      cpu_addr = tbl[i].addr; ext_addr = tbl[i].addr; c_bus = tbl[i].data; ext_wdata = tbl[i].data;
      wait_ack(lat, who_cpu);
      chk($sformatf("tbl%0d latency", i), lat, tbl[i].lat);
      chk($sformatf("tbl%0d owner", i), who_cpu, tbl[i].cpu);
      if (tbl[i].we) chk($sformatf("tbl%0d dram write", i), {sn_a, sn_d}, {tbl[i].addr, tbl[i].data});
      settle();
    end

    for (int i = 0; i < 3000; i++) begin
      @(posedge clk);
      #1;
      dram_rdata = 8'($urandom);
      c_bus = 8'($urandom);
      if (!cpu_req && $urandom_range(2) == 0) begin
        cpu_req = 1; cpu_we = 1'($urandom); cpu_addr = 16'($urandom);
      end else if (cpu_req && $urandom_range(5) == 0) cpu_req = 0;
      if (!ext_req && $urandom_range(2) == 0) begin
        ext_req = 1; ext_we = 1'($urandom); ext_addr = 16'($urandom); ext_wdata = 8'($urandom);
      end else if (ext_req && $urandom_range(5) == 0) ext_req = 0;
      if ($urandom_range(400) == 0) begin
        #2 rstn = 0;
        #2 rstn = 1;
      end
    end
    settle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequences every DRAM transaction for the 8-bit downsampling processor and drives the memory data register's strobes (read_memory, write_memory).
- Arbitrates a single DRAM port between two requesters: the CPU control unit and the external image load/dump port (ext).
- CPU transactions move data through the memory data register. Ext transactions bypass it, using their own write data and a captured read register.

Parameters:
ADDR_W, 16, DRAM address width
READ_LAT, 2, cycles from the DRAM read-issue cycle to the cycle dram_rdata is valid; legal range 1..15

Ports:
clk  in  1  system clock, rising edge
rstn  in  1  asynchronous active-low reset
cpu_req  in  1  CPU transaction request, level; held until cpu_ack
cpu_we  in  1  CPU direction: 1 = write, 0 = read; stable while cpu_req is high
cpu_addr  in  ADDR_W  CPU address; stable while cpu_req is high
cpu_ack  out  1  one-cycle pulse; CPU transaction complete
ext_req  in  1  ext request, level; held until ext_ack
ext_we  in  1  ext direction: 1 = write, 0 = read
ext_addr  in  ADDR_W  ext address
ext_wdata  in  8  ext write data; stable while ext_req is high
ext_rdata  out  8  ext read data; valid from the ext_ack cycle until the next ext read capture
ext_ack  out  1  one-cycle pulse; ext transaction complete
mdr_wdata  in  8  memory data register's write-data output (data_write_DRAM)
read_memory  out  1  strobe; memory data register loads dram_rdata
write_memory  out  1  strobe; memory data register loads c_bus into its write register
dram_en  out  1  DRAM access enable
dram_we  out  1  DRAM write enable; meaningful only when dram_en is high
dram_addr  out  ADDR_W  DRAM address
dram_wdata  out  8  DRAM write data
dram_rdata  in  8  DRAM read data
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rstn low, asynchronous):
  - state = IDLE; every output is 0; addr_q = 0; ext_rdata = 0.
  - last_grant = EXT, so the CPU wins the first contention.
  - Reset asserted mid-transaction abandons the transaction; no ack is issued.
- States: IDLE, W_LATCH, W_ISSUE, R_ISSUE, R_WAIT, R_CAPT, ACK.
- All outputs are Moore outputs decoded from registered state and registered qualifiers.
- Registers: owner (CPU/EXT), addr_q, we_q, wait counter (4 bits).
- IDLE arbitration:
  - Only one requester high: grant it.
  - Both high: grant the one that is not last_grant (round-robin).
  - On grant: latch owner, addr_q, we_q; update last_grant.
  - Next state:
    - CPU write -> W_LATCH
    - EXT write -> W_ISSUE
    - any read -> R_ISSUE
- W_LATCH (CPU only): write_memory = 1 for one cycle; the memory data register captures c_bus at the closing edge. Next state W_ISSUE.
- W_ISSUE:
  - dram_en = 1, dram_we = 1, dram_addr = addr_q.
  - dram_wdata = mdr_wdata if owner is CPU, ext_wdata if owner is EXT.
  - Next state ACK.
- R_ISSUE:
  - dram_en = 1, dram_we = 0, dram_addr = addr_q.
  - Load counter with READ_LAT-1.
  - Next state R_WAIT if READ_LAT > 1, otherwise R_CAPT.
- R_WAIT: counter decrements each cycle; move to R_CAPT when it reaches 1.
- R_CAPT:
  - dram_rdata is valid this cycle.
  - Owner CPU: read_memory = 1.
  - Owner EXT: ext_rdata <= dram_rdata at the closing edge.
  - Next state ACK.
- ACK: the owner's ack = 1 for one cycle; next state IDLE. Requests are not sampled in ACK.
- dram_addr holds addr_q in all states; dram_wdata = 0 outside W_ISSUE.
- Latency, counting the IDLE grant cycle as T0:
  - CPU write: ack at T3.
  - EXT write: ack at T2.
  - Any read: ack at T(READ_LAT+2).
- Back-to-back: a request still high in the IDLE cycle after ACK is a new transaction. This gives a minimum of one IDLE cycle between transactions.
- Continuous contention alternates grants CPU, EXT, CPU, ...
- A request dropped before its ack is ignored; the transaction completes and the ack still pulses.
- At most one of read_memory, write_memory, cpu_ack, ext_ack is high in any cycle.

Test Plan:
1. Reset mid-transaction: rstn low during R_WAIT -> all outputs 0 immediately; IDLE after release; no ack; next contention granted to CPU.
2. CPU write, addr 0x0123, c_bus 0xA5 -> write_memory at T1; T2 has dram_en=1, dram_we=1, dram_addr=0x0123, dram_wdata=0xA5; cpu_ack at T3 only.
3. CPU read, READ_LAT=2, dram_rdata=0x3C at T3 -> dram_en at T1 with dram_we=0; read_memory at T3; memory data register holds 0x3C; cpu_ack at T4.
4. EXT read, READ_LAT=1, dram_rdata=0x7E -> ext_rdata=0x7E and ext_ack in the same cycle at T3; read_memory never asserted.
5. cpu_req and ext_req held high continuously, both writes -> grant order CPU, EXT, CPU, EXT; acks alternate; one IDLE cycle between transactions.
6. EXT write, ext_wdata=0xFF, addr 0xFFFF (all ones) -> dram_wdata=0xFF at T1 in W_ISSUE; write_memory stays 0; ext_ack at T2.
